// File: rtl/memory_controller_pkg.sv
// -----------------------------------------------------------------------------
// memory_controller_pkg
// Shared definitions for the byte-command memory front end:
//   - command byte codes recognised in IDLE
//   - FSM state enumeration (also exported on the debug state port)
// -----------------------------------------------------------------------------
package memory_controller_pkg;

  localparam logic [7:0] COMMAND_WRITE = 8'h01;
  localparam logic [7:0] COMMAND_READ  = 8'h02;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE       = 3'd0,
    ST_LEN        = 3'd1,
    ST_ADDR_HI    = 3'd2,
    ST_ADDR_LO    = 3'd3,
    ST_WDATA      = 3'd4,
    ST_READ_FETCH = 3'd5,
    ST_READ_SEND  = 3'd6,
    ST_READ_WAIT  = 3'd7
  } state_e;

endpackage

// File: rtl/memory_controller_byte_ram.sv
// -----------------------------------------------------------------------------
// byte_ram
// Single-port synchronous byte RAM with registered read (1-cycle latency).
// Contents are not reset.
// Ports:
//   clk_i    clock
//   we_i     write enable; wdata_i stored at addr_i on the rising edge
//   addr_i   shared read/write address
//   wdata_i  write data
//   rdata_o  registered read data of addr_i (old data on read-during-write)
// -----------------------------------------------------------------------------
module byte_ram #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [7:0]            wdata_i,
  output logic [7:0]            rdata_o
);

  logic [7:0] mem_q [0:(1<<ADDR_WIDTH)-1];
  logic [7:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/memory_controller.sv
// -----------------------------------------------------------------------------
// memory_controller
// Parses byte commands from a UART receiver and services them against an
// on-chip byte RAM. Frame: CMD, LEN, ADDR_HI, ADDR_LO, [payload for writes].
// Burst length is LEN+1; the address wraps modulo 2^ADDR_WIDTH.
// Ports:
//   clock            system clock (rising edge)
//   reset            synchronous active-high reset
//   received         one-cycle strobe, rx_byte valid
//   rx_byte          byte from the UART receiver
//   is_transmitting  UART transmitter busy flag
//   transmit         one-cycle strobe to start sending tx_byte
//   tx_byte          byte to transmit, held until the next transmit strobe
//   state_o          debug view of the FSM state (state_e encoding)
//
// Handshake: received is a fire-and-forget strobe (no back-pressure); bytes
// arriving during a read burst are dropped. transmit fires only from
// READ_SEND on an edge where is_transmitting is low; READ_WAIT gives the
// transmitter one cycle to raise its busy flag before the next byte.
// -----------------------------------------------------------------------------
module memory_controller
  import memory_controller_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         received,
  input  logic [7:0]   rx_byte,
  input  logic         is_transmitting,
  output logic         transmit,
  output logic [7:0]   tx_byte,
  output logic [2:0]   state_o
);

  state_e                state_q, state_d;
  logic                  is_read_q, is_read_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            addr_hi_q, addr_hi_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  transmit_q, transmit_d;
  logic [7:0]            tx_byte_q, tx_byte_d;

  logic                  ram_we;
  logic [7:0]            ram_rdata;

  // The RAM always addresses addr_q: writes land there in WDATA, and the
  // registered read of addr_q issued in READ_FETCH is valid in READ_SEND.
  // addr_q does not move while waiting in READ_SEND, so the data stays
  // stable for however long the transmitter is busy.
  byte_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk_i   (clock),
    .we_i    (ram_we),
    .addr_i  (addr_q),
    .wdata_i (rx_byte),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      is_read_q  <= 1'b0;
      len_q      <= 8'h00;
      addr_hi_q  <= 8'h00;
      addr_q     <= '0;
      transmit_q <= 1'b0;
      tx_byte_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      is_read_q  <= is_read_d;
      len_q      <= len_d;
      addr_hi_q  <= addr_hi_d;
      addr_q     <= addr_d;
      transmit_q <= transmit_d;
      tx_byte_q  <= tx_byte_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    is_read_d  = is_read_q;
    len_d      = len_q;
    addr_hi_d  = addr_hi_q;
    addr_d     = addr_q;
    transmit_d = 1'b0;
    tx_byte_d  = tx_byte_q;
    ram_we     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (received && (rx_byte == COMMAND_WRITE || rx_byte == COMMAND_READ)) begin
          is_read_d = (rx_byte == COMMAND_READ);
          state_d   = ST_LEN;
        end
      end

      ST_LEN: begin
        if (received) begin
          len_d   = rx_byte;
          state_d = ST_ADDR_HI;
        end
      end

      ST_ADDR_HI: begin
        if (received) begin
          addr_hi_d = rx_byte;
          state_d   = ST_ADDR_LO;
        end
      end

      ST_ADDR_LO: begin
        if (received) begin
          // Upper address bits beyond the RAM depth are discarded.
          addr_d  = ADDR_WIDTH'({addr_hi_q, rx_byte});
          state_d = is_read_q ? ST_READ_FETCH : ST_WDATA;
        end
      end

      ST_WDATA: begin
        if (received) begin
          ram_we = 1'b1;
          addr_d = addr_q + ADDR_WIDTH'(1);
          // len_q counts remaining bytes minus one.
          if (len_q == 8'h00) begin
            state_d = ST_IDLE;
          end else begin
            len_d = len_q - 8'd1;
          end
        end
      end

      ST_READ_FETCH: begin
        state_d = ST_READ_SEND;
      end

      ST_READ_SEND: begin
        if (!is_transmitting) begin
          transmit_d = 1'b1;
          tx_byte_d  = ram_rdata;
          addr_d     = addr_q + ADDR_WIDTH'(1);
          state_d    = ST_READ_WAIT;
        end
      end

      ST_READ_WAIT: begin
        if (len_q == 8'h00) begin
          state_d = ST_IDLE;
        end else begin
          len_d   = len_q - 8'd1;
          state_d = ST_READ_FETCH;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign transmit = transmit_q;
  assign tx_byte  = tx_byte_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_memory_controller.sv
// -----------------------------------------------------------------------------
// tb_memory_controller
// Directed bench for memory_controller: command frames driven byte by byte,
// transmitted bytes collected by a monitor and compared against an expected
// queue filled with hand-computed values.
// -----------------------------------------------------------------------------
module tb_memory_controller;

  logic       clock;
  logic       reset;
  logic       received;
  logic [7:0] rx_byte;
  logic       is_transmitting;
  logic       transmit;
  logic [7:0] tx_byte;
  logic [2:0] state_o;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int t0       = 0;

  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int         obs_cyc_q[$];

  logic busy_at_edge = 1'b0;
  logic prev_tx      = 1'b0;

  memory_controller #(.ADDR_WIDTH(12)) dut (
    .clock           (clock),
    .reset           (reset),
    .received        (received),
    .rx_byte         (rx_byte),
    .is_transmitting (is_transmitting),
    .transmit        (transmit),
    .tx_byte         (tx_byte),
    .state_o         (state_o)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc          <= cyc + 1;
    busy_at_edge <= is_transmitting;
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (transmit === 1'b1) begin
      check("tx_only_when_idle", {31'd0, busy_at_edge}, 32'd0);
      check("tx_not_back_to_back", {31'd0, prev_tx}, 32'd0);
      obs_q.push_back(tx_byte);
      obs_cyc_q.push_back(cyc);
    end
    prev_tx = transmit;
  end

  // ---------------- drivers ----------------
  // All driver tasks start and end on a falling edge.
  task automatic send_byte(input logic [7:0] b);
    received = 1'b1;
    rx_byte  = b;
    @(negedge clock);
    received = 1'b0;
    rx_byte  = 8'h00;
  endtask

  task automatic send_hdr(input logic [7:0] c, input logic [7:0] l,
                          input logic [7:0] hi, input logic [7:0] lo);
    send_byte(c);
    send_byte(l);
    send_byte(hi);
    send_byte(lo);
    t0 = cyc;  // edge count at which ADDR_LO was sampled
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_obs(input string tag, input int n, input int budget);
    int k = 0;
    while (obs_q.size() < n && k < budget) begin
      @(negedge clock);
      k++;
    end
    check(tag, obs_q.size(), n);
  endtask

  // ---------------- scoreboard ----------------
  task automatic drain_expected(input string tag);
    logic [7:0] got;
    while (exp_q.size() > 0) begin
      got = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      check(tag, {24'd0, got}, {24'd0, exp_q.pop_front()});
    end
    check({tag, "_no_extra"}, obs_q.size(), 0);
    obs_q.delete();
    obs_cyc_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset           = 1'b1;
    received        = 1'b0;
    rx_byte         = 8'h00;
    is_transmitting = 1'b0;
    idle(3);
    check("reset_transmit", {31'd0, transmit}, 32'd0);
    check("reset_tx_byte",  {24'd0, tx_byte},  32'd0);
    check("reset_state",    {29'd0, state_o},  32'd0);
    reset = 1'b0;
    idle(2);

    // Test 1: burst of 3, timing of pulses
    send_hdr(8'h01, 8'h02, 8'h0E, 8'hCD);
    send_byte(8'h42); send_byte(8'h43); send_byte(8'h44);
    check("write_back_idle", {29'd0, state_o}, 32'd0);
    send_hdr(8'h02, 8'h02, 8'h0E, 8'hCD);
    wait_obs("t1_count", 3, 40);
    if (obs_cyc_q.size() == 3) begin
      check("t1_first_latency", obs_cyc_q[0] - t0, 2);
      check("t1_gap_1", obs_cyc_q[1] - obs_cyc_q[0], 3);
      check("t1_gap_2", obs_cyc_q[2] - obs_cyc_q[1], 3);
    end
    exp_q.push_back(8'h42); exp_q.push_back(8'h43); exp_q.push_back(8'h44);
    drain_expected("t1_data");
    idle(3);
    check("t1_back_idle", {29'd0, state_o}, 32'd0);

    // Test 2: transmitter busy after first pulse
    send_hdr(8'h01, 8'h02, 8'h0A, 8'h10);
    send_byte(8'h44); send_byte(8'h45); send_byte(8'h46);
    send_hdr(8'h02, 8'h02, 8'h0A, 8'h10);
    wait_obs("t2_first", 1, 20);
    is_transmitting = 1'b1;
    idle(5);
    check("t2_held_while_busy", obs_q.size(), 1);
    is_transmitting = 1'b0;
    wait_obs("t2_count", 3, 40);
    idle(10);
    exp_q.push_back(8'h44); exp_q.push_back(8'h45); exp_q.push_back(8'h46);
    drain_expected("t2_data");

    // Test 3: address wrap 0xFFF -> 0x000; 0x001 preloaded with 5A
    send_hdr(8'h01, 8'h00, 8'h00, 8'h01);
    send_byte(8'h5A);
    send_hdr(8'h01, 8'h01, 8'h0F, 8'hFF);
    send_byte(8'hAA); send_byte(8'hBB);
    send_hdr(8'h02, 8'h01, 8'h00, 8'h00);
    wait_obs("t3_count", 2, 40);
    idle(10);
    exp_q.push_back(8'hBB); exp_q.push_back(8'h5A);
    drain_expected("t3_wrap");
    // Upper address bits are ignored: 0xF0FF maps to 0x0FF... read 0xFFF via 0x1FFF
    send_hdr(8'h02, 8'h00, 8'h1F, 8'hFF);
    wait_obs("t3b_count", 1, 20);
    idle(10);
    exp_q.push_back(8'hAA);
    drain_expected("t3b_high_bits");

    // Test 4: unknown command ignored
    send_byte(8'h7F);
    check("t4_unknown_idle", {29'd0, state_o}, 32'd0);
    send_hdr(8'h02, 8'h00, 8'h0E, 8'hCD);
    wait_obs("t4_count", 1, 20);
    idle(10);
    exp_q.push_back(8'h42);
    drain_expected("t4_data");

    // Test 5: reset mid-frame
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h0E);
    reset = 1'b1;
    idle(1);
    check("t5_reset_transmit", {31'd0, transmit}, 32'd0);
    check("t5_reset_state", {29'd0, state_o}, 32'd0);
    reset = 1'b0;
    send_byte(8'hCD);  // would have been ADDR_LO; must be ignored now
    send_byte(8'h11);
    check("t5_still_idle", {29'd0, state_o}, 32'd0);
    send_hdr(8'h02, 8'h00, 8'h0E, 8'hCD);
    wait_obs("t5_count", 1, 20);
    idle(10);
    exp_q.push_back(8'h42);
    drain_expected("t5_data");

    // Test 6: LEN=0 single-byte burst
    send_hdr(8'h01, 8'h00, 8'h00, 8'h05);
    send_byte(8'h99);
    send_hdr(8'h02, 8'h00, 8'h00, 8'h05);
    wait_obs("t6_count", 1, 20);
    idle(15);
    exp_q.push_back(8'h99);
    drain_expected("t6_data");

    // Test 7: received bytes during a read are dropped
    send_hdr(8'h02, 8'h00, 8'h0A, 8'h10);
    send_byte(8'h01);
    wait_obs("t7_count", 1, 20);
    idle(5);
    check("t7_idle_after", {29'd0, state_o}, 32'd0);
    exp_q.push_back(8'h44);
    drain_expected("t7_data");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
